// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin arbiter that shares the single downstream cache
// bus between cache-side requesters (0 = ICache, 1 = DCache, ...). One owner
// holds the bus for a whole burst; response beats return only to that owner.
module cbus_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  // Requester side
  input  logic [NREQ-1:0]      m_valid_i,
  input  logic [NREQ-1:0]      m_is_write_i,
  input  logic [NREQ*3-1:0]    m_size_i,
  input  logic [NREQ*32-1:0]   m_addr_i,
  input  logic [NREQ*4-1:0]    m_strobe_i,
  input  logic [NREQ*32-1:0]   m_data_i,
  input  logic [NREQ*4-1:0]    m_len_i,
  output logic [NREQ-1:0]      m_ready_o,
  output logic [NREQ-1:0]      m_last_o,
  output logic [31:0]          m_rdata_o,
  // Downstream cache bus
  output logic                 c_valid_o,
  output logic                 c_is_write_o,
  output logic [2:0]           c_size_o,
  output logic [31:0]          c_addr_o,
  output logic [3:0]           c_strobe_o,
  output logic [31:0]          c_data_o,
  output logic [3:0]           c_len_o,
  input  logic                 c_ready_i,
  input  logic                 c_last_i,
  input  logic [31:0]          c_rdata_i
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              found_s;
  logic [IDXW-1:0]   pick_s;

  // Index of the k-th requester in scan order starting at the round-robin pointer.
  function automatic logic [IDXW-1:0] rr_idx(input logic [IDXW-1:0] base, input int k);
    return IDXW'((int'(base) + k) % NREQ);
  endfunction

  // Round-robin pick: first valid requester scanning from rr_ptr upward, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      logic [IDXW-1:0] cand_s;
      logic            hit_s;
      cand_s  = rr_idx(rr_ptr_q, k);
      hit_s   = m_valid_i[cand_s] & ~found_s;
      pick_s  = hit_s ? cand_s : pick_s;
      found_s = found_s | hit_s;
    end
  end

  // Next-state: grant from IDLE, release on the final downstream handshake.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = BUSY;
          owner_d = pick_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (c_ready_i && c_last_i) begin
          state_d  = IDLE;
          // The owner just served drops to lowest priority next time round.
          rr_ptr_d = (owner_q == IDXW'(NREQ - 1)) ? IDXW'(0) : owner_q + IDXW'(1);
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output mux: route owner's request downstream and the handshake back to it only.
  always_comb begin
    c_valid_o    = 1'b0;
    c_is_write_o = 1'b0;
    c_size_o     = 3'd0;
    c_addr_o     = 32'd0;
    c_strobe_o   = 4'd0;
    c_data_o     = 32'd0;
    c_len_o      = 4'd0;
    m_ready_o    = '0;
    m_last_o     = '0;
    m_rdata_o    = c_rdata_i;
    case (state_q)
      IDLE: begin
        c_valid_o = 1'b0;
      end
      BUSY: begin
        // A dropped m_valid from the owner simply shows up as c_valid=0.
        c_valid_o    = m_valid_i[owner_q];
        c_is_write_o = m_is_write_i[owner_q];
        c_size_o     = m_size_i[int'(owner_q)*3 +: 3];
        c_addr_o     = m_addr_i[int'(owner_q)*32 +: 32];
        c_strobe_o   = m_strobe_i[int'(owner_q)*4 +: 4];
        c_data_o     = m_data_i[int'(owner_q)*32 +: 32];
        c_len_o      = m_len_i[int'(owner_q)*4 +: 4];
        for (int i = 0; i < NREQ; i++) begin
          m_ready_o[i] = (owner_q == IDXW'(i)) & c_ready_i;
          m_last_o[i]  = (owner_q == IDXW'(i)) & c_last_i;
        end
      end
      default: begin
        c_valid_o = 1'b0;
      end
    endcase
  end

  // State, owner and round-robin pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Testbench for cbus_arbiter: requester and downstream-bus models driven from
// one process, with a scoreboard of expected grants (owner, address, length,
// write data) consumed as downstream beats handshake.
module tb_cbus_arbiter;

  localparam int NREQ = 2;
  localparam int IDXW = 1;

  logic                clk;
  logic                resetn;
  logic [NREQ-1:0]     m_valid, m_is_write, m_ready, m_last;
  logic [NREQ*3-1:0]   m_size;
  logic [NREQ*32-1:0]  m_addr, m_data;
  logic [NREQ*4-1:0]   m_strobe, m_len;
  logic [31:0]         m_rdata;
  logic                c_valid, c_is_write, c_ready, c_last;
  logic [2:0]          c_size;
  logic [31:0]         c_addr, c_data, c_rdata;
  logic [3:0]          c_strobe, c_len;

  cbus_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
    .clk(clk), .resetn(resetn),
    .m_valid_i(m_valid), .m_is_write_i(m_is_write), .m_size_i(m_size),
    .m_addr_i(m_addr), .m_strobe_i(m_strobe), .m_data_i(m_data), .m_len_i(m_len),
    .m_ready_o(m_ready), .m_last_o(m_last), .m_rdata_o(m_rdata),
    .c_valid_o(c_valid), .c_is_write_o(c_is_write), .c_size_o(c_size),
    .c_addr_o(c_addr), .c_strobe_o(c_strobe), .c_data_o(c_data), .c_len_o(c_len),
    .c_ready_i(c_ready), .c_last_i(c_last), .c_rdata_i(c_rdata)
  );

  // Free-running clock, period 20.
  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int          owner;
    logic [31:0] addr;
    logic [3:0]  len;
    logic        wr;
    logic [3:0]  strb;
  } exp_t;

  exp_t        sb[$];
  int          rem[NREQ];
  int          beat[NREQ];
  logic        drop[NREQ];
  logic [31:0] addr_r[NREQ];
  logic [3:0]  len_r[NREQ];
  logic        wr_r[NREQ];
  logic [3:0]  strb_r[NREQ];
  logic [31:0] data_tab[NREQ][4];
  int          pulse[NREQ];
  logic        resp_en;
  int          cnt;
  int          cyc;
  int          last_hs;
  logic        gap_en;
  logic        prev_cv;
  logic [NREQ-1:0] hs_rdy, hs_lst;
  logic        c_hs, c_lhs;
  int          checks;
  int          errors;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int o);
    exp_t e;
    e.owner = o;
    e.addr  = addr_r[o];
    e.len   = len_r[o];
    e.wr    = wr_r[o];
    e.strb  = strb_r[o];
    sb.push_back(e);
  endtask

  // Apply requester models, then the downstream responder once outputs settle.
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      m_valid[i]          = (rem[i] > 0) && !drop[i];
      m_is_write[i]       = wr_r[i];
      m_size[i*3 +: 3]    = 3'd2;
      m_addr[i*32 +: 32]  = addr_r[i];
      m_strobe[i*4 +: 4]  = strb_r[i];
      m_data[i*32 +: 32]  = data_tab[i][beat[i]];
      m_len[i*4 +: 4]     = len_r[i];
    end
    #1;
    c_ready = resp_en && c_valid;
    c_last  = c_ready && (cnt == int'(c_len));
    c_rdata = 32'hA500_0000 + 32'(cnt);
    #1;
  endtask

  // Mid-cycle observation of DUT outputs against the scoreboard.
  task automatic monitor();
    exp_t e;
    cyc++;
    hs_rdy = m_ready;
    hs_lst = m_last;
    c_hs   = c_valid && c_ready;
    c_lhs  = c_hs && c_last;
    for (int i = 0; i < NREQ; i++) if (m_ready[i]) pulse[i]++;
    if (!c_ready) begin
      check_eq("ready_without_cready", 32'(m_ready), 32'd0);
      check_eq("last_without_cready", 32'(m_last), 32'd0);
    end
    if (gap_en && c_valid && !prev_cv && last_hs >= 0)
      check_eq("turnaround_gap", 32'(cyc - last_hs), 32'd2);
    prev_cv = c_valid;
    if (c_hs) begin
      check_eq("sb_has_entry", {31'd0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        e = sb[0];
        check_eq("grant_owner", 32'(m_ready), 32'd1 << e.owner);
        check_eq("c_addr", c_addr, e.addr);
        check_eq("c_len", 32'(c_len), 32'(e.len));
        check_eq("c_is_write", 32'(c_is_write), 32'(e.wr));
        check_eq("c_strobe", 32'(c_strobe), 32'(e.strb));
        check_eq("c_data", c_data, data_tab[e.owner][cnt]);
        check_eq("m_rdata", m_rdata, 32'hA500_0000 + 32'(cnt));
        check_eq("m_last", 32'(m_last), c_last ? (32'd1 << e.owner) : 32'd0);
        if (c_last) begin
          void'(sb.pop_front());
          last_hs = cyc;
        end
      end
    end
  endtask

  // Requester and responder bookkeeping just after the active edge.
  task automatic update();
    if (!resetn) begin
      cnt = 0;
    end else begin
      if (c_hs) cnt = c_lhs ? 0 : cnt + 1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_rdy[i]) begin
          if (hs_lst[i]) begin
            rem[i]--;
            beat[i] = 0;
          end else begin
            beat[i]++;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    update();
    drive();
  endtask

  task automatic run(input int max);
    int n;
    n = 0;
    while (sb.size() > 0 && n < max) begin
      step();
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; cnt = 0; last_hs = -1;
    gap_en = 1'b0; prev_cv = 1'b0; resp_en = 1'b1; resetn = 1'b0;
    c_ready = 1'b0; c_last = 1'b0; c_rdata = 32'd0;
    hs_rdy = '0; hs_lst = '0; c_hs = 1'b0; c_lhs = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; beat[i] = 0; drop[i] = 1'b0; len_r[i] = 4'd0;
      wr_r[i] = 1'b0; strb_r[i] = 4'd0; pulse[i] = 0;
      for (int b = 0; b < 4; b++) data_tab[i][b] = 32'h1111_0000 * 32'(i + 1) + 32'(b);
    end
    data_tab[1][0] = 32'hDEAD_BEEF;
    data_tab[1][1] = 32'h1234_5678;
    addr_r[0] = 32'h1FC0_0000;
    addr_r[1] = 32'h8000_1000;

    // Reset held 3 cycles with both requesters valid.
    rem[0] = 1; rem[1] = 1;
    drive();
    @(posedge clk);
    #1;
    drive();
    for (int r = 0; r < 3; r++) begin
      step();
      check_eq("rst_c_valid", 32'(c_valid), 32'd0);
      check_eq("rst_m_ready", 32'(m_ready), 32'd0);
      check_eq("rst_c_addr", c_addr, 32'd0);
    end
    resetn = 1'b1;
    push(0); push(1);
    drive();
    check_eq("arb_cycle_c_valid", 32'(c_valid), 32'd0);
    step();
    check_eq("first_grant_c_valid", 32'(c_valid), 32'd1);
    check_eq("first_grant_addr", c_addr, 32'h1FC0_0000);
    run(50);

    // ICache 4-beat read.
    for (int i = 0; i < NREQ; i++) pulse[i] = 0;
    len_r[0] = 4'd3; rem[0] = 1; push(0);
    drive();
    run(50);
    check_eq("icache_ready_pulses", 32'(pulse[0]), 32'd4);
    check_eq("dcache_ready_pulses", 32'(pulse[1]), 32'd0);
    check_eq("after_release_c_valid", 32'(c_valid), 32'd0);
    len_r[0] = 4'd0;

    // rr_ptr now 1: DCache wins a simultaneous request.
    rem[0] = 1; rem[1] = 1; push(1); push(0);
    drive();
    run(50);
    rem[1] = 1; push(1);
    drive();
    run(50);

    // Both continuously valid, 3 single-beat transactions each.
    gap_en = 1'b1; last_hs = -1;
    rem[0] = 3; rem[1] = 3;
    for (int t = 0; t < 3; t++) begin push(0); push(1); end
    drive();
    run(100);
    gap_en = 1'b0;

    // DCache write burst, ICache raises valid mid-burst.
    len_r[1] = 4'd1; wr_r[1] = 1'b1; strb_r[1] = 4'hF; rem[1] = 1; push(1);
    drive();
    step();
    check_eq("wr_beat1_data", c_data, 32'hDEAD_BEEF);
    step();
    rem[0] = 1; push(0);
    drive();
    check_eq("wr_beat2_data", c_data, 32'h1234_5678);
    check_eq("wr_beat2_addr", c_addr, 32'h8000_1000);
    run(50);
    len_r[1] = 4'd0; wr_r[1] = 1'b0; strb_r[1] = 4'd0;

    // Owner drops m_valid for one cycle mid-burst; DCache waiting.
    len_r[0] = 4'd3; rem[0] = 1; push(0);
    drive();
    step();
    step();
    drop[0] = 1'b1; rem[1] = 1; push(1);
    drive();
    check_eq("drop_c_valid", 32'(c_valid), 32'd0);
    check_eq("drop_m_ready", 32'(m_ready), 32'd0);
    step();
    drop[0] = 1'b0;
    drive();
    check_eq("drop_resume_c_valid", 32'(c_valid), 32'd1);
    check_eq("drop_owner_kept", c_addr, 32'h1FC0_0000);
    run(50);
    len_r[0] = 4'd0;

    // Reset during beat 2 of a DCache 4-beat burst (rr_ptr=1 beforehand).
    rem[0] = 1; push(0);
    drive();
    run(50);
    len_r[1] = 4'd3; rem[1] = 1; push(1);
    drive();
    step();
    step();
    resetn = 1'b0;
    step();
    sb.delete();
    resetn = 1'b1;
    len_r[1] = 4'd0;
    for (int i = 0; i < NREQ; i++) begin rem[i] = 1; beat[i] = 0; end
    push(0); push(1);
    drive();
    check_eq("post_rst_c_valid", 32'(c_valid), 32'd0);
    check_eq("post_rst_m_ready", 32'(m_ready), 32'd0);
    check_eq("post_rst_m_last", 32'(m_last), 32'd0);
    step();
    check_eq("post_rst_grant_addr", c_addr, 32'h1FC0_0000);
    run(50);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Round-robin arbiter sharing the single downstream cache bus (cbus) between multiple cache-side requesters (ICache refill, DCache refill/writeback, uncached access path). It sits between the caches behind the MMU and the AXI bridge. It grants one requester per transaction, holds the grant for the full burst, and returns response beats only to the owner.

## Interface
- NREQ, 2: number of requesters; port 0 = ICache, 1 = DCache; legal 2..4
- IDXW, $clog2(NREQ): width of owner index
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- m_valid  in  NREQ  per-requester request valid; held high until the requester's last beat completes
- m_is_write  in  NREQ  per-requester write flag
- m_size  in  NREQ×3  per-requester transfer size
- m_addr  in  NREQ×32  per-requester start address
- m_strobe  in  NREQ×4  per-requester write byte strobes
- m_data  in  NREQ×32  per-requester write data for the current beat
- m_len  in  NREQ×4  per-requester burst length code (beats = m_len+1)
- m_ready  out  NREQ  beat accepted/returned; asserted only on the owner's bit
- m_last  out  NREQ  final beat; asserted only on the owner's bit
- m_rdata  out  32  read data, broadcast to all requesters; meaningful only with the owner's m_ready
- c_valid, c_is_write, c_size, c_addr, c_strobe, c_data, c_len  out  1/1/3/32/4/32/4  downstream request fields
- c_ready  in  1  downstream beat handshake
- c_last  in  1  downstream final beat
- c_rdata  in  32  downstream read data

## Operation
- State machine with two states, IDLE and BUSY. Registers: state, owner[IDXW-1:0], rr_ptr[IDXW-1:0].
- IDLE:
  - All c_* outputs are 0.
  - All m_ready and m_last are 0.
  - If any m_valid is high, select the first valid index scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - On the next edge, latch it into owner and go to BUSY.
- BUSY:
  - c_* request fields are driven combinationally from requester[owner]. c_valid = m_valid[owner].
  - m_ready[owner] = c_ready and m_last[owner] = c_last. All other bits are 0.
  - m_rdata = c_rdata at all times.
  - Non-owner requests are held off: no handshake and no side effect on them.
- Release:
  - In BUSY, when c_ready && c_last, go to IDLE on the next edge.
  - On that same edge, rr_ptr <= owner+1, wrapping to 0 at NREQ-1.
- Fairness: a requester that was just served has the lowest priority in the next arbitration.
  - With all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.
- Grant stability:
  - owner never changes in BUSY.
  - m_valid[owner] dropping before the last beat is a protocol violation. The arbiter stays BUSY and forwards c_valid=0 until c_last handshakes.
- Requests that remain valid after their own last beat are treated as new requests in the next IDLE cycle.

## Timing
- Reset (resetn=0 at an edge): state=IDLE, owner=0, rr_ptr=0.
  - Outputs immediately after reset: c_valid=0, all c_* fields 0, m_ready=0, m_last=0.
  - Any in-flight burst is abandoned. The downstream bridge is reset by the same resetn.
- Grant latency:
  - A request valid in IDLE at edge k appears on c_valid in cycle k+1.
  - IDLE to first c_valid takes exactly 1 cycle.
- Data beats pass combinationally with zero added latency in both directions.
- Turnaround: the last beat handshakes at edge j, the arbiter is IDLE in cycle j+1, and the next grant drives c_valid in cycle j+2.
  - Minimum gap between back-to-back transactions is 1 idle cycle.
- Simultaneous requests at the same edge: resolved by rr_ptr only. Arrival order inside a cycle is irrelevant.
- Single-beat transaction (len=0): c_ready and c_last arrive in the same cycle, and release follows the same rule.

## Test plan
- Reset: hold resetn=0 for 3 cycles with m_valid=2'b11.
  - Required: c_valid=0 and m_ready=0 throughout.
  - After release: owner=0 granted, c_valid=1 in the first cycle after the IDLE arbitration edge.
- ICache 4-beat read (m_len[0]=3, addr 0x1FC0_0000) with c_ready high on 4 consecutive cycles and c_last on the 4th.
  - Required: m_ready[0] pulses 4 times, m_last[0] on beat 4, m_ready[1] stays 0.
  - Required: arbiter returns to IDLE, rr_ptr=1.
- Both valid continuously, 3 single-beat transactions each.
  - Required: grant order 0,1,0,1,0,1.
  - Required: each c_valid rise is exactly 2 cycles after the previous c_last handshake.
- DCache write burst (m_len[1]=1, strobe 4'hF, data 0xDEADBEEF then 0x12345678) while ICache raises valid mid-burst.
  - Required: c_data follows requester 1 for both beats, ICache is not granted until after c_last.
- Owner drops m_valid for one cycle mid-burst.
  - Required: c_valid=0 that cycle, owner unchanged, state stays BUSY until c_last.
- Reset asserted during beat 2 of a 4-beat burst.
  - Required: the next cycle is IDLE, owner=0, rr_ptr=0, m_ready=0, no m_last delivered.
